neural_layer_engine: RTL and testbench
======================================

NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 Parameter DW, default 8: signed data width of weights, neuron values and results.
REQ-002 Parameter AW, default 8: width of all addresses and of the n_in/n_out counts.
REQ-003 Parameter ACCW, default 2*DW+8: signed accumulator width.
REQ-004 Parameter FRAC, default 0: arithmetic right shift applied to the accumulator before activation.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to run one layer; sampled only in IDLE.
REQ-008 n_in  in  AW  input-neuron count of the layer.
REQ-009 n_out  in  AW  output-neuron count of the layer.
REQ-010 w_base / x_base / y_base  in  AW each  weight, input-neuron and output-neuron base addresses.
REQ-011 relu_en  in  1  1 = ReLU activation, 0 = identity.
REQ-012 w_addr  out  AW  weight memory read address; w_data  in  DW  read data, valid one cycle after the address.
REQ-013 x_addr  out  AW  neuron memory read address; x_data  in  DW  read data, valid one cycle after the address.
REQ-014 y_addr  out  AW, y_data  out  DW, y_we  out  1  neuron memory write port; a write occurs on the edge where y_we=1.
REQ-015 busy  out  1  layer in progress; done  out  1  one-cycle completion pulse; err  out  1  completion flag for an illegal layer.

Function
REQ-016 The engine SHALL capture n_in, n_out, all bases and relu_en on the edge start is accepted; later input changes SHALL NOT affect the running layer.
REQ-017 FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE -> RUN on start with n_in!=0 and n_out!=0.
- IDLE -> DONE with err=1 otherwise.
REQ-018 RUN SHALL last n_in cycles per output neuron j.
- In cycle i it issues w_addr = w_base + j*n_in + i and x_addr = x_base + i.
- In the same cycle it accumulates the product of the data returned for the previous cycle's address (none in i=0).
- All address sums wrap modulo 2^AW.
REQ-019 DRAIN (1 cycle) SHALL accumulate the final product.
REQ-020 WRITE (1 cycle) SHALL do all of the following:
- Assert y_we with y_addr = y_base + j and y_data = sat(act(acc >>> FRAC)).
- Clear the accumulator.
- Go to RUN for j+1, or to DONE when j = n_out-1.
REQ-021 Products SHALL be signed DW x DW; accumulation SHALL be signed ACCW-bit, wrapping on overflow (no intermediate saturation).
REQ-022 act SHALL output max(v,0) when relu_en=1 and v unchanged otherwise; sat SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 Each output neuron SHALL take exactly n_in+2 cycles.
- The first RUN cycle is the cycle after start is accepted.
- done SHALL pulse in the cycle after the last WRITE, i.e. n_out*(n_in+2)+1 cycles after acceptance.
REQ-024 DONE SHALL last one cycle, assert done (and err if illegal), then return to IDLE; err SHALL be 0 on legal layers.
REQ-025 busy SHALL be 1 in RUN, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-026 start while not in IDLE (busy or DONE) SHALL be ignored, with no queuing.
REQ-027 y_we SHALL be 1 only in WRITE; an illegal layer SHALL produce no writes.
REQ-028 When not in RUN, w_addr and x_addr SHALL hold their last values; their contents are don't-care.

Reset
REQ-029 While reset=1 the engine SHALL enter IDLE and clear the accumulator, the counters and the captured configuration.
REQ-030 While reset=1 the outputs SHALL be: busy=0, done=0, err=0, y_we=0, y_addr=0, y_data=0, w_addr=0, x_addr=0.
REQ-031 Reset mid-layer SHALL abort on that edge with no further writes; reset SHALL take priority over start in the same cycle.

Verification
REQ-032 DW=8, FRAC=0, n_in=2, n_out=1, w={3,4}, x={5,6}, y_base=0x20, relu_en=0 -> a single y_we with y_addr=0x20, y_data=39, and done 5 cycles after acceptance.
REQ-033 n_in=2, n_out=1, w={127,127}, x={127,127} -> y_data=127 (saturated); w={-128,-128}, x={127,127} -> y_data=-128.
REQ-034 n_in=1, n_out=1, w={-3}, x={5}: relu_en=1 -> y_data=0; relu_en=0 -> y_data=0xF1 (-15).
REQ-035 n_in=3, n_out=2, w_base=0xFE -> weight addresses 0xFE,0xFF,0x00 then 0x01,0x02,0x03; y_addr = y_base, y_base+1; done at cycle 11.
REQ-036 n_in=0 -> done=1 and err=1 in the cycle after acceptance, no y_we; start pulsed while busy -> ignored, result unchanged.
REQ-037 reset asserted during the RUN phase of neuron 1 of 2 -> next cycle busy=0, y_we=0, and no write to y_base+1; a fresh start then completes normally.

Source files
------------

// File: rtl/neural_layer_engine.sv
// Fully-connected layer engine: streams weights and input neurons from two
// synchronous-read memories, accumulates one dot product per output neuron.
module neural_layer_engine #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int ACCW = 2*DW+8,
  parameter int FRAC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] n_in,
  input  logic [AW-1:0] n_out,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] y_base,
  input  logic          relu_en,
  output logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_data,
  output logic [AW-1:0] y_addr,
  output logic [DW-1:0] y_data,
  output logic          y_we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 <<< (DW-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - ACCW'(1);

  state_t                 r_state;
  state_t                 w_next;
  logic        [AW-1:0]   r_n_in;
  logic        [AW-1:0]   r_n_out;
  logic        [AW-1:0]   r_x_base;
  logic        [AW-1:0]   r_y_base;
  logic                   r_relu;
  logic                   r_err;
  logic        [AW-1:0]   r_i;
  logic        [AW-1:0]   r_j;
  logic        [AW-1:0]   r_w_addr;
  logic        [AW-1:0]   r_x_addr;
  logic signed [ACCW-1:0] r_acc;

  logic                   w_legal;
  logic                   w_last_i;
  logic                   w_last_j;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_shift;

  function automatic logic signed [ACCW-1:0] act_f(input logic signed [ACCW-1:0] v,
                                                   input logic relu);
    return (relu && (v < 0)) ? '0 : v;
  endfunction

  function automatic logic [DW-1:0] sat_f(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] c;
    c = v;
    if (v > SAT_MAX) c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    return c[DW-1:0];
  endfunction

  assign w_legal    = (n_in != '0) && (n_out != '0);
  assign w_last_i   = (r_i == r_n_in - AW'(1));
  assign w_last_j   = (r_j == r_n_out - AW'(1));
  assign w_prod     = $signed(w_data) * $signed(x_data);
  assign w_prod_ext = ACCW'(w_prod);
  assign w_shift    = r_acc >>> FRAC;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    y_we   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = w_legal ? S_RUN : S_DONE;
      S_RUN: begin
        busy = 1'b1;
        if (w_last_i) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        y_we   = 1'b1;
        w_next = w_last_j ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Addresses advance by one per RUN cycle; the weight pointer simply keeps
  // counting across neurons, which equals w_base + j*n_in + i modulo 2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_in   <= '0;
      r_n_out  <= '0;
      r_x_base <= '0;
      r_y_base <= '0;
      r_relu   <= 1'b0;
      r_err    <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_w_addr <= '0;
      r_x_addr <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_n_in   <= n_in;
          r_n_out  <= n_out;
          r_x_base <= x_base;
          r_y_base <= y_base;
          r_relu   <= relu_en;
          r_err    <= !w_legal;
          r_i      <= '0;
          r_j      <= '0;
          r_acc    <= '0;
          if (w_legal) begin
            r_w_addr <= w_base;
            r_x_addr <= x_base;
          end
        end
        S_RUN: begin
          if (r_i != '0) r_acc <= r_acc + w_prod_ext;
          if (!w_last_i) begin
            r_i      <= r_i + AW'(1);
            r_w_addr <= r_w_addr + AW'(1);
            r_x_addr <= r_x_addr + AW'(1);
          end
        end
        S_DRAIN: r_acc <= r_acc + w_prod_ext;
        S_WRITE: begin
          r_acc <= '0;
          r_i   <= '0;
          if (!w_last_j) begin
            r_j      <= r_j + AW'(1);
            r_w_addr <= r_w_addr + AW'(1);
            r_x_addr <= r_x_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr = r_w_addr;
  assign x_addr = r_x_addr;
  assign y_addr = r_y_base + r_j;
  assign y_data = sat_f(act_f(w_shift, r_relu));

endmodule

// File: tb/tb_neural_layer_engine.sv
// Bench for neural_layer_engine: directed vector table, hand-written corner
// sequences and random layers checked against a dot-product reference model.
module tb_neural_layer_engine;

  logic       clk = 1'b0;
  logic       reset, start, relu_en;
  logic [7:0] n_in, n_out, w_base, x_base, y_base;
  logic [7:0] w_addr, x_addr, y_addr, y_data;
  logic [7:0] w_data, x_data;
  logic       y_we, busy, done, err;

  logic [7:0] wmem [256];
  logic [7:0] nmem [256];

  int total = 0;
  int bad   = 0;

  int wa [256];
  int xa [256];
  int wr_a [64];
  int wr_d [64];
  int wr_c [64];
  int nwr, done_cyc, err_seen, busy_bad;

  typedef struct {
    int ni, no, wb, xb, yb, relu;
    int w0, w1, x0, x1;
    int exp_y, exp_nwr, exp_done, exp_err;
  } vec_t;

  neural_layer_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .n_in(n_in), .n_out(n_out), .w_base(w_base), .x_base(x_base), .y_base(y_base),
    .relu_en(relu_en),
    .w_addr(w_addr), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
    .y_addr(y_addr), .y_data(y_data), .y_we(y_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_data <= wmem[w_addr];
    x_data <= nmem[x_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain dot product, wrapped to the 24-bit accumulator, then ReLU and clamp.
  function automatic int model_y(int ni, int j, int wb, int xb, int relu);
    longint acc;
    logic [63:0] raw;
    logic signed [23:0] a;
    acc = 0;
    for (int i = 0; i < ni; i++)
      acc += longint'($signed(wmem[8'(wb + j*ni + i)])) * longint'($signed(nmem[8'(xb + i)]));
    raw = acc;
    a = raw[23:0];
    if (relu != 0 && a < 0) a = 0;
    if (a > 127) return 127;
    if (a < -128) return 128;
    return int'(a) & 255;
  endfunction

  task automatic run_layer(input int ni, input int no, input int wb, input int xb,
                           input int yb, input int relu, input int poke);
    int budget;
    n_in = 8'(ni); n_out = 8'(no); w_base = 8'(wb); x_base = 8'(xb); y_base = 8'(yb);
    relu_en = (relu != 0);
    start = 1'b1;
    step();
    start = 1'b0;
    nwr = 0; done_cyc = -1; err_seen = 0; busy_bad = 0;
    budget = no*(ni+2) + 8;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      wa[c & 255] = int'(w_addr);
      xa[c & 255] = int'(x_addr);
      if (y_we && nwr < 64) begin
        wr_a[nwr] = int'(y_addr); wr_d[nwr] = int'(y_data); wr_c[nwr] = c; nwr++;
      end
      if (done) begin
        done_cyc = c; err_seen = int'(err);
        if (busy) busy_bad++;
      end else if (!busy) busy_bad++;
      if (c == poke) begin
        start = 1'b1; n_in = 8'd5; n_out = 8'd3; w_base = 8'h33;
        x_base = 8'h44; y_base = 8'h55; relu_en = ~relu_en;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
  endtask

  task automatic check_layer(input int ni, input int no, input int wb, input int xb,
                             input int yb, input int relu, input int poke);
    int addr_bad, c;
    run_layer(ni, no, wb, xb, yb, relu, poke);
    chk("layer_nwr", nwr, no);
    chk("layer_done_cycle", done_cyc, no*(ni+2) + 1);
    chk("layer_err", err_seen, 0);
    chk("layer_busy", busy_bad, 0);
    for (int j = 0; j < no && j < nwr; j++) begin
      chk("layer_y_addr", wr_a[j], (yb + j) & 255);
      chk("layer_y_data", wr_d[j], model_y(ni, j, wb, xb, relu));
      chk("layer_wr_cycle", wr_c[j], (j+1)*(ni+2));
    end
    addr_bad = 0;
    for (int j = 0; j < no; j++)
      for (int i = 0; i < ni; i++) begin
        c = j*(ni+2) + 1 + i;
        if (wa[c & 255] != ((wb + j*ni + i) & 255) || xa[c & 255] != ((xb + i) & 255))
          addr_bad++;
      end
    chk("layer_rd_addr", addr_bad, 0);
  endtask

  initial begin
    vec_t vt [7];
    int cnt;

    vt[0] = '{2, 1, 8'h00, 8'h10, 8'h20, 0,    3,    4,   5,   6,   39, 1, 5, 0};
    vt[1] = '{2, 1, 8'h00, 8'h10, 8'h20, 0,  127,  127, 127, 127,  127, 1, 5, 0};
    vt[2] = '{2, 1, 8'h00, 8'h10, 8'h20, 0, -128, -128, 127, 127, -128, 1, 5, 0};
    vt[3] = '{1, 1, 8'h00, 8'h10, 8'h21, 1,   -3,    0,   5,   0,    0, 1, 4, 0};
    vt[4] = '{1, 1, 8'h00, 8'h10, 8'h22, 0,   -3,    0,   5,   0,  -15, 1, 4, 0};
    vt[5] = '{0, 1, 8'h00, 8'h10, 8'h20, 0,    1,    1,   1,   1,    0, 0, 1, 1};
    vt[6] = '{3, 0, 8'h00, 8'h10, 8'h20, 0,    1,    1,   1,   1,    0, 0, 1, 1};

    for (int k = 0; k < 256; k++) begin
      wmem[k] = 8'($urandom);
      nmem[k] = 8'($urandom);
    end

    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    n_in = '0; n_out = '0; w_base = '0; x_base = '0; y_base = '0;
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_y_we", int'(y_we), 0);
    chk("rst_y_addr", int'(y_addr), 0);
    chk("rst_y_data", int'(y_data), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_x_addr", int'(x_addr), 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      wmem[8'(vt[v].wb)]     = 8'(vt[v].w0);
      wmem[8'(vt[v].wb + 1)] = 8'(vt[v].w1);
      nmem[8'(vt[v].xb)]     = 8'(vt[v].x0);
      nmem[8'(vt[v].xb + 1)] = 8'(vt[v].x1);
      run_layer(vt[v].ni, vt[v].no, vt[v].wb, vt[v].xb, vt[v].yb, vt[v].relu, 0);
      chk("vec_nwr", nwr, vt[v].exp_nwr);
      chk("vec_done_cycle", done_cyc, vt[v].exp_done);
      chk("vec_err", err_seen, vt[v].exp_err);
      if (vt[v].exp_nwr > 0 && nwr > 0) begin
        chk("vec_y_data", wr_d[0], vt[v].exp_y & 255);
        chk("vec_y_addr", wr_a[0], vt[v].yb);
      end
      step();
    end

    // Weight address wrap across the top of the address space.
    check_layer(3, 2, 8'hFE, 8'h08, 8'h40, 0, 0);
    chk("wrap_w0", wa[1], 8'hFE);
    chk("wrap_w2", wa[3], 8'h00);
    chk("wrap_w3", wa[6], 8'h01);
    chk("wrap_w5", wa[8], 8'h03);
    step();

    // A start pulse with altered inputs during RUN must change nothing.
    check_layer(4, 3, 8'h20, 8'h08, 8'hA0, 1, 2);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy || y_we || done) cnt++;
      step();
    end
    chk("busy_start_ignored", cnt, 0);

    // Reset in the RUN phase of the second neuron, together with a start.
    n_in = 8'd3; n_out = 8'd2; w_base = 8'h10; x_base = 8'h00; y_base = 8'h90;
    relu_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (y_we) cnt++;
      step();
    end
    chk("midrst_pre_writes", cnt, 1);
    chk("midrst_busy_before", int'(busy), 1);
    reset = 1'b1; start = 1'b1;
    step();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_y_we", int'(y_we), 0);
    chk("midrst_done", int'(done), 0);
    reset = 1'b0; start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (y_we || busy || done) cnt++;
      step();
    end
    chk("midrst_after_activity", cnt, 0);
    check_layer(3, 2, 8'h10, 8'h00, 8'h90, 0, 0);
    step();

    for (int r = 0; r < 6; r++) begin
      check_layer(int'($urandom_range(1, 12)), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                  int'($urandom_range(8'h80, 8'hF0)), int'($urandom_range(0, 1)), 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
